// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serialising issue sequencer in front of the polynomial ALU.
// Fetches both operands from the register file, loads the ALU, waits for
// compute_done (bounded by a timeout) and writes one or two results back.
//
// Handshake: an instruction transfers on a rising edge where ins_vld and
// ins_rdy are both high. ins_rdy depends only on internal state (high only
// in IDLE) and never on ins_vld; the source may hold ins_vld high and change
// the payload freely while ins_rdy is low, and nothing is captured then.
module alu_issue_ctrl #(
  parameter int DAT_W = 144,
  parameter int RA_W  = 4,
  parameter int TMO_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_vld,
  output logic              ins_rdy,
  input  logic [3:0]        ins_typ,
  input  logic [RA_W-1:0]   ins_src_o,
  input  logic [RA_W-1:0]   ins_src_t,
  input  logic [RA_W-1:0]   ins_dst1,
  input  logic [RA_W-1:0]   ins_dst2,
  input  logic              ins_wr2,
  output logic [RA_W-1:0]   rf_rd_addr_o,
  output logic [RA_W-1:0]   rf_rd_addr_t,
  input  logic [DAT_W:0]    rf_rd_dat_o,
  input  logic [DAT_W-1:0]  rf_rd_dat_t,
  input  logic [DAT_W:0]    mod_dat,
  output logic [3:0]        alu_typ_sel,
  output logic              alu_o_sel,
  output logic              alu_t_sel,
  output logic              alu_mod_sel,
  output logic [DAT_W:0]    alu_o_dat,
  output logic [DAT_W-1:0]  alu_t_dat,
  output logic [DAT_W:0]    alu_mod_dat,
  input  logic [DAT_W-1:0]  alu_r_dat1,
  input  logic [DAT_W-1:0]  alu_r_dat2,
  input  logic              compute_done,
  output logic              rf_wr_en,
  output logic [RA_W-1:0]   rf_wr_addr,
  output logic [DAT_W:0]    rf_wr_dat,
  output logic              busy,
  output logic              err,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_LD   = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_WB1  = 3'd5;
  localparam logic [2:0] S_WB2  = 3'd6;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [3:0]       typ_q;
  logic [RA_W-1:0]  dst1_q;
  logic [RA_W-1:0]  dst2_q;
  logic             wr2_q;
  logic             ld_second;
  logic [TMO_W-1:0] tmo_cnt;
  logic [DAT_W-1:0] r1_q;
  logic [DAT_W-1:0] r2_q;
  logic             two_cyc;
  logic             mod_op;
  logic             tmo_hit;

  // mult and div need their operands presented for two cycles
  assign two_cyc = (typ_q == 4'b0011) || (typ_q == 4'b0101);
  // only mult, shift and eval consume the modulus
  assign mod_op  = (typ_q == 4'b0011) || (typ_q == 4'b1000) || (typ_q == 4'b1001);
  assign tmo_hit = (tmo_cnt == TMO_MAX);
  assign fsm_state = state;

  // Next-state selection for the issue sequence
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ins_vld) state_nxt = S_RD;
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = S_LD;
      S_LD:    if (!two_cyc || ld_second) state_nxt = S_WAIT;
      S_WAIT: begin
        // a completion in the same cycle as the timeout still wins
        if (compute_done)  state_nxt = S_WB1;
        else if (tmo_hit)  state_nxt = S_IDLE;
      end
      S_WB1:   state_nxt = wr2_q ? S_WB2 : S_IDLE;
      S_WB2:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Instruction fields and read addresses, captured on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      typ_q        <= '0;
      dst1_q       <= '0;
      dst2_q       <= '0;
      wr2_q        <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_rd_addr_t <= '0;
    end else if (state == S_IDLE && ins_vld) begin
      typ_q        <= ins_typ;
      dst1_q       <= ins_dst1;
      dst2_q       <= ins_dst2;
      wr2_q        <= ins_wr2;
      rf_rd_addr_o <= ins_src_o;
      rf_rd_addr_t <= ins_src_t;
    end
  end

  // Operand registers, loaded once register-file data has arrived
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_o_dat   <= '0;
      alu_t_dat   <= '0;
      alu_mod_dat <= '0;
    end else if (state == S_CAP) begin
      alu_o_dat   <= rf_rd_dat_o;
      alu_t_dat   <= rf_rd_dat_t;
      alu_mod_dat <= mod_dat;
    end
  end

  // Strobe length tracking and compute_done timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_second <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      ld_second <= (state == S_LD) && !ld_second;
      if (state == S_LD)                  tmo_cnt <= '0;
      else if (state == S_WAIT && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Result registers, loaded only on a completion seen while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q <= '0;
      r2_q <= '0;
    end else if (state == S_WAIT && compute_done) begin
      r1_q <= alu_r_dat1;
      r2_q <= alu_r_dat2;
    end
  end

  // Outputs decoded from state so reset removes them without a clock
  always_comb begin
    ins_rdy     = (state == S_IDLE);
    busy        = (state != S_IDLE);
    alu_o_sel   = (state == S_LD);
    alu_t_sel   = (state == S_LD);
    alu_mod_sel = (state == S_LD) && mod_op;
    alu_typ_sel = 4'b0000;
    rf_wr_en    = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_dat   = '0;
    err         = (state == S_WAIT) && tmo_hit && !compute_done;
    if (state == S_LD || state == S_WAIT) alu_typ_sel = typ_q;
    if (state == S_WB1) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = dst1_q;
      rf_wr_dat  = {1'b0, r1_q};
    end else if (state == S_WB2) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = dst2_q;
      rf_wr_dat  = {1'b0, r2_q};
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomised issue traffic for alu_issue_ctrl
// with a register-file model, a behavioural ALU responder and a write-back
// scoreboard.
module tb_alu_issue_ctrl;

  localparam int DAT_W = 144;
  localparam int RA_W  = 4;
  localparam int TMO_W = 10;
  localparam int WQ    = RA_W + DAT_W + 1;

  typedef struct {
    logic [3:0]       typ;
    int               len;
    logic             mod;
    logic [DAT_W:0]   o;
    logic [DAT_W-1:0] t;
    int               d;
    bit               stray;
    bit               abort;
    int               tacc;
  } ins_t;

  logic              clk;
  logic              rst;
  logic              ins_vld;
  logic              ins_rdy;
  logic [3:0]        ins_typ;
  logic [RA_W-1:0]   ins_src_o, ins_src_t, ins_dst1, ins_dst2;
  logic              ins_wr2;
  logic [RA_W-1:0]   rf_rd_addr_o, rf_rd_addr_t;
  logic [DAT_W:0]    rf_rd_dat_o;
  logic [DAT_W-1:0]  rf_rd_dat_t;
  logic [DAT_W:0]    mod_dat;
  logic [3:0]        alu_typ_sel;
  logic              alu_o_sel, alu_t_sel, alu_mod_sel;
  logic [DAT_W:0]    alu_o_dat;
  logic [DAT_W-1:0]  alu_t_dat;
  logic [DAT_W:0]    alu_mod_dat;
  logic [DAT_W-1:0]  alu_r_dat1, alu_r_dat2;
  logic              compute_done;
  logic              rf_wr_en;
  logic [RA_W-1:0]   rf_wr_addr;
  logic [DAT_W:0]    rf_wr_dat;
  logic              busy;
  logic              err;
  logic [2:0]        fsm_state;

  logic [DAT_W:0]    rf_o [16];
  logic [DAT_W-1:0]  rf_t [16];
  logic [DAT_W:0]    wr_mem [16];
  logic [WQ-1:0]     exp_q[$];
  ins_t              exp_ins_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int exp_err  = 0;
  int next_free = 0;

  alu_issue_ctrl #(.DAT_W(DAT_W), .RA_W(RA_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .ins_vld(ins_vld), .ins_rdy(ins_rdy),
    .ins_typ(ins_typ), .ins_src_o(ins_src_o), .ins_src_t(ins_src_t),
    .ins_dst1(ins_dst1), .ins_dst2(ins_dst2), .ins_wr2(ins_wr2),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_addr_t(rf_rd_addr_t),
    .rf_rd_dat_o(rf_rd_dat_o), .rf_rd_dat_t(rf_rd_dat_t), .mod_dat(mod_dat),
    .alu_typ_sel(alu_typ_sel), .alu_o_sel(alu_o_sel), .alu_t_sel(alu_t_sel),
    .alu_mod_sel(alu_mod_sel), .alu_o_dat(alu_o_dat), .alu_t_dat(alu_t_dat),
    .alu_mod_dat(alu_mod_dat), .alu_r_dat1(alu_r_dat1), .alu_r_dat2(alu_r_dat2),
    .compute_done(compute_done), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_dat(rf_wr_dat), .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // register file: read data one cycle after the address
  always @(posedge clk) begin
    rf_rd_dat_o <= rf_o[rf_rd_addr_o];
    rf_rd_dat_t <= rf_t[rf_rd_addr_t];
  end

  // ---------------- reference helpers ----------------
  function automatic logic [DAT_W-1:0] f1(input logic [3:0] typ, input logic [DAT_W:0] o,
                                          input logic [DAT_W-1:0] t);
    return o[DAT_W-1:0] + t + {{(DAT_W-4){1'b0}}, typ};
  endfunction

  function automatic logic [DAT_W-1:0] f2(input logic [3:0] typ, input logic [DAT_W:0] o,
                                          input logic [DAT_W-1:0] t);
    return o[DAT_W-1:0] ^ ~t ^ {typ, {(DAT_W-4){1'b0}}};
  endfunction

  function automatic logic [DAT_W:0] rnd_word();
    logic [159:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return v[DAT_W:0];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called aligned to a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] typ, input logic [RA_W-1:0] so, input logic [RA_W-1:0] st,
                       input logic [RA_W-1:0] d1, input logic [RA_W-1:0] d2, input logic w2,
                       input int d, input bit stray, input bit abort, input bit keep,
                       input bit chk_gap);
    ins_t e;
    int k;
    ins_typ = typ; ins_src_o = so; ins_src_t = st;
    ins_dst1 = d1; ins_dst2 = d2; ins_wr2 = w2; ins_vld = 1'b1;
    k = 0;
    while (!ins_rdy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!ins_rdy) begin
      check("accept_wait", 256'(ins_rdy), 256'(1));
      ins_vld = 1'b0;
      return;
    end
    if (chk_gap) check("b2b_gap", 256'(cyc), 256'(next_free));
    e.typ   = typ;
    e.len   = (typ == 4'b0011 || typ == 4'b0101) ? 2 : 1;
    e.mod   = (typ == 4'b0011 || typ == 4'b1000 || typ == 4'b1001);
    e.o     = rf_o[so];
    e.t     = rf_t[st];
    e.d     = d;
    e.stray = stray;
    e.abort = abort;
    e.tacc  = cyc;
    exp_ins_q.push_back(e);
    if (!abort) begin
      if (d > 0) begin
        exp_q.push_back({d1, 1'b0, f1(typ, e.o, e.t)});
        if (w2) exp_q.push_back({d2, 1'b0, f2(typ, e.o, e.t)});
        next_free = cyc + e.len + d + int'(w2) + 4;
      end else begin
        exp_err++;
      end
    end
    @(negedge clk);
    if (!keep) ins_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 256'(busy), 256'(0));
  endtask

  // ---------------- ALU responder and load-phase monitor ----------------
  initial begin : alu_model
    ins_t e;
    int n;
    compute_done = 1'b0;
    alu_r_dat1 = '0;
    alu_r_dat2 = '0;
    forever begin
      @(negedge clk);
      if (alu_o_sel) begin
        if (exp_ins_q.size() == 0) begin
          check("unexpected_strobe", 256'(alu_o_sel), 256'(0));
        end else begin
          e = exp_ins_q.pop_front();
          check("ld_cycle", 256'(e.tacc + 3 - cyc), 256'(0));
          check("typ_sel_ld", 256'(alu_typ_sel), 256'(e.typ));
          check("t_sel", 256'(alu_t_sel), 256'(1));
          check("mod_sel", 256'(alu_mod_sel), 256'(e.mod));
          check("o_dat", 256'(alu_o_dat), 256'(e.o));
          check("t_dat", 256'(alu_t_dat), 256'(e.t));
          check("mod_dat", 256'(alu_mod_dat), 256'(mod_dat));
          alu_r_dat1 = f1(alu_typ_sel, alu_o_dat, alu_t_dat);
          alu_r_dat2 = f2(alu_typ_sel, alu_o_dat, alu_t_dat);
          if (e.stray) compute_done = 1'b1;
          n = 1;
          @(negedge clk);
          compute_done = 1'b0;
          while (alu_o_sel && n < 4) begin
            n++;
            @(negedge clk);
          end
          if (!e.abort) begin
            check("strobe_len", 256'(n), 256'(e.len));
            check("typ_sel_wait", 256'(alu_typ_sel), 256'(e.typ));
            if (e.d > 0) begin
              repeat (e.d - 1) @(negedge clk);
              compute_done = 1'b1;
              @(negedge clk);
              compute_done = 1'b0;
              check("wb1_cycle", 256'(rf_wr_en), 256'(1));
              check("typ_sel_wb", 256'(alu_typ_sel), 256'(0));
            end else begin
              repeat (1023) @(negedge clk);
              check("tmo_err_cycle", 256'(err), 256'(1));
            end
          end
        end
      end
    end
  end

  // ---------------- write-back scoreboard ----------------
  initial begin : wr_monitor
    logic [WQ-1:0] e;
    forever begin
      @(negedge clk);
      if (err) err_cnt++;
      if (rf_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 256'(rf_wr_en), 256'(0));
        end else begin
          e = exp_q.pop_front();
          check("wr_addr_data", 256'({rf_wr_addr, rf_wr_dat}), 256'(e));
        end
        wr_mem[rf_wr_addr] = rf_wr_dat;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int k;
    logic [3:0] typ;
    logic [DAT_W-1:0] r2_exp;
    rst = 1'b0;
    ins_vld = 1'b0; ins_typ = '0; ins_src_o = '0; ins_src_t = '0;
    ins_dst1 = '0; ins_dst2 = '0; ins_wr2 = 1'b0;
    mod_dat = {1'b1, 100'h0, 44'h000_0000_082b};
    for (int i = 0; i < 16; i++) begin
      rf_o[i]   = rnd_word();
      rf_t[i]   = rnd_word() >> 1;
      wr_mem[i] = '0;
    end
    #1 rst = 1'b1;
    #2;
    check("rst_ins_rdy", 256'(ins_rdy), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_wr_en", 256'(rf_wr_en), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_strobes", 256'({alu_o_sel, alu_t_sel, alu_mod_sel}), 256'(0));
    check("rst_typ_sel", 256'(alu_typ_sel), 256'(0));
    check("rst_rd_addr", 256'({rf_rd_addr_o, rf_rd_addr_t}), 256'(0));
    check("rst_operands", 256'(alu_o_dat | alu_mod_dat), 256'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // add, D = 1, single write
    rf_o[1] = {{(DAT_W-15){1'b0}}, 16'hfff1};
    rf_t[2] = {{(DAT_W-16){1'b0}}, 16'h0f0f};
    issue(4'b0001, 4'd1, 4'd2, 4'd9, 4'd10, 1'b0, 1, 0, 0, 0, 0);
    check("add_busy", 256'(busy), 256'(1));
    n = 1;
    while (!ins_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("add_accept_to_rdy", 256'(n), 256'(6));
    wait_idle();

    // mult with modulus, done after 100 cycles
    issue(4'b0011, 4'd3, 4'd4, 4'd11, 4'd12, 1'b0, 100, 0, 0, 0, 0);
    wait_idle();

    // split writes, then same destination twice
    issue(4'b0010, 4'd5, 4'd6, 4'd3, 4'd4, 1'b1, 3, 0, 0, 0, 0);
    wait_idle();
    r2_exp = f2(4'b0010, rf_o[7], rf_t[8]);
    issue(4'b0010, 4'd7, 4'd8, 4'd5, 4'd5, 1'b1, 2, 0, 0, 0, 0);
    wait_idle();
    check("same_dst_final", 256'(wr_mem[5]), 256'({1'b0, r2_exp}));

    // timeout on div with a stray done during LD
    issue(4'b0101, 4'd9, 4'd10, 4'd13, 4'd14, 1'b0, 0, 1, 0, 0, 0);
    wait_idle();
    check("tmo_err_count", 256'(err_cnt), 256'(1));
    check("tmo_rdy", 256'(ins_rdy), 256'(1));

    // reset while a mult waits for completion
    issue(4'b0011, 4'd2, 4'd3, 4'd6, 4'd7, 1'b0, 0, 0, 1, 0, 0);
    k = 0;
    while (!alu_o_sel && k < 20) begin @(negedge clk); k++; end
    while (alu_o_sel && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_wait_busy", 256'(busy), 256'(0));
    check("rst_wait_rdy", 256'(ins_rdy), 256'(1));
    check("rst_wait_wr_en", 256'(rf_wr_en), 256'(0));
    check("rst_wait_typ_sel", 256'(alu_typ_sel), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_release_rdy", 256'(ins_rdy), 256'(1));

    // reset while a mult is loading
    issue(4'b0011, 4'd4, 4'd5, 4'd6, 4'd7, 1'b0, 0, 0, 1, 0, 0);
    k = 0;
    while (!alu_o_sel && k < 20) begin @(negedge clk); k++; end
    #2 rst = 1'b1;
    #1;
    check("rst_ld_strobes", 256'({alu_o_sel, alu_t_sel, alu_mod_sel}), 256'(0));
    check("rst_ld_busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ld_err_count", 256'(err_cnt), 256'(1));

    // back-to-back with ins_vld held high
    issue(4'b0001, 4'd1, 4'd2, 4'd1, 4'd2, 1'b0, 2, 0, 0, 1, 0);
    issue(4'b0101, 4'd3, 4'd4, 4'd3, 4'd4, 1'b1, 1, 0, 0, 1, 1);
    issue(4'b1001, 4'd5, 4'd6, 4'd5, 4'd6, 1'b0, 4, 0, 0, 0, 1);
    wait_idle();

    // randomised traffic, including unknown opcodes
    for (int i = 0; i < 24; i++) begin
      typ = 4'($urandom_range(0, 15));
      issue(typ, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom_range(1, 8), 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    repeat (4) @(negedge clk);
    check("wr_q_drained", 256'(exp_q.size()), 256'(0));
    check("ins_q_drained", 256'(exp_ins_q.size()), 256'(0));
    check("err_count", 256'(err_cnt), 256'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
